// File: rtl/simd_alu_pkg.sv
// Shared types and helpers for the SIMD vector ALU.
// SIMD_ALU_GFMUL_EN enables the GF(2^8) multiply opcode (8-bit lanes only).
package simd_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_DIV   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_SRL   = 4'd6,
        OP_SLL   = 4'd7,
        OP_NOP   = 4'd8,
        OP_XOR   = 4'd9,
        OP_ROTL  = 4'd10,
        OP_GFMUL = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic carry;
        logic ovf;
    } lane_flags_t;

`ifdef SIMD_ALU_GFMUL_EN
    localparam bit GFMUL_BUILD = 1'b1;

    // AES field multiply, reduction polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul8(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
        end
        return p;
    endfunction
`else
    localparam bit GFMUL_BUILD = 1'b0;
`endif

    function automatic logic is_legal_op(input logic [3:0] op, input int unsigned lane_w);
        return (op <= 4'd10) || (GFMUL_BUILD && (op == 4'd11) && (lane_w == 32'd8));
    endfunction

endpackage

// File: rtl/simd_vector_alu_if.sv
// Operand/result bus of the SIMD vector ALU; master drives operands, slave is the ALU.
interface simd_vector_alu_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8
);
    localparam int unsigned VW = LANES * LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [LANES-1:0]  lane_en;
    logic [VW-1:0]     a;
    logic [VW-1:0]     b;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     result;
    logic [LANES-1:0]  neg_flag;
    logic [LANES-1:0]  zero_flag;
    logic [LANES-1:0]  carry_flag;
    logic [LANES-1:0]  ovf_flag;
    logic              nop_flag;
    logic              err_flag;

    modport master (
        output in_valid, op, lane_en, a, b, out_ready,
        input  in_ready, out_valid, result, neg_flag, zero_flag, carry_flag, ovf_flag,
               nop_flag, err_flag
    );

    modport slave (
        input  in_valid, op, lane_en, a, b, out_ready,
        output in_ready, out_valid, result, neg_flag, zero_flag, carry_flag, ovf_flag,
               nop_flag, err_flag
    );
endinterface

// File: rtl/simd_alu_lane.sv
// Combinational single-lane compute; disabled lanes pass a through with flags cleared.
// GF(2^8) datapath present only with SIMD_ALU_GFMUL_EN and LANE_W == 8.
module simd_alu_lane
    import simd_alu_pkg::*;
#(
    parameter int unsigned LANE_W = 8
) (
    input  logic [3:0]        op,
    input  logic              en,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] res,
    output lane_flags_t       flags,
    output logic              div0
);
    localparam int unsigned SH_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam int unsigned PW   = 2 * LANE_W;

    logic [LANE_W:0]     sum_c;
    logic [PW-1:0]       prod_c;
    logic [SH_W-1:0]     sh_c;
    logic [LANE_W-1:0]   raw_c;
    logic                carry_c;
    logic                ovf_c;
    logic                legal_c;

    assign sum_c   = {1'b0, a} + {1'b0, b};
    assign prod_c  = PW'(a) * PW'(b);
    assign sh_c    = b[SH_W-1:0];
    assign legal_c = is_legal_op(op, LANE_W);

`ifdef SIMD_ALU_GFMUL_EN
    logic [LANE_W-1:0] gf_c;
    if (LANE_W == 8) begin : g_gf
        assign gf_c = LANE_W'(gf_mul8(8'(a), 8'(b)));
    end else begin : g_no_gf
        assign gf_c = '0;
    end
`endif

    always_comb begin
        raw_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        div0    = 1'b0;
        case (alu_op_e'(op))
            OP_ADD: begin
                raw_c   = sum_c[LANE_W-1:0];
                carry_c = sum_c[LANE_W];
                ovf_c   = (a[LANE_W-1] == b[LANE_W-1]) && (sum_c[LANE_W-1] != a[LANE_W-1]);
            end
            OP_SUB: begin
                raw_c   = a - b;
                carry_c = a < b;
                ovf_c   = (a[LANE_W-1] != b[LANE_W-1]) && (raw_c[LANE_W-1] != a[LANE_W-1]);
            end
            OP_MUL: begin
                raw_c   = prod_c[LANE_W-1:0];
                carry_c = |prod_c[PW-1:LANE_W];
            end
            OP_DIV: begin
                if (b == '0) begin
                    raw_c = '1;
                    div0  = en;
                end else begin
                    raw_c = a / b;
                end
            end
            OP_AND:  raw_c = a & b;
            OP_OR:   raw_c = a | b;
            OP_XOR:  raw_c = a ^ b;
            OP_SRL:  raw_c = a >> sh_c;
            OP_SLL:  raw_c = a << sh_c;
            // right shift by LANE_W when sh is 0 yields 0, so no special case
            OP_ROTL: raw_c = (a << sh_c) | (a >> (LANE_W - 32'(sh_c)));
`ifdef SIMD_ALU_GFMUL_EN
            OP_GFMUL: raw_c = gf_c;
`endif
            default: raw_c = '0;
        endcase

        res   = en ? raw_c : a;
        flags = '0;
        if (en && legal_c && (op != OP_NOP)) begin
            flags.neg   = raw_c[LANE_W-1];
            flags.zero  = (raw_c == '0);
            flags.carry = carry_c;
            flags.ovf   = ovf_c;
        end
    end
endmodule

// File: rtl/simd_vector_alu.sv
// Two-stage SIMD ALU: S1 captures the operand beat, S2 captures lane results and flags.
// Optional GF(2^8) multiply via SIMD_ALU_GFMUL_EN.
module simd_vector_alu
    import simd_alu_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    simd_vector_alu_if.slave  bus
);
    localparam int unsigned VW = LANES * LANE_W;

    logic              s1_valid_q, s1_valid_d;
    logic [3:0]        s1_op_q, s1_op_d;
    logic [LANES-1:0]  s1_en_q, s1_en_d;
    logic [VW-1:0]     s1_a_q, s1_a_d;
    logic [VW-1:0]     s1_b_q, s1_b_d;

    logic              out_valid_q, out_valid_d;
    logic [VW-1:0]     result_q, result_d;
    logic [LANES-1:0]  neg_q, neg_d, zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
    logic              nop_q, nop_d, err_q, err_d;

    logic              adv1_c, adv2_c;
    logic [VW-1:0]     lane_res_c;
    lane_flags_t       lane_flags_c [LANES];
    logic [LANES-1:0]  div0_c;
    logic [LANES-1:0]  neg_c, zero_c, carry_c, ovf_c;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        simd_alu_lane #(.LANE_W(LANE_W)) u_lane (
            .op    (s1_op_q),
            .en    (s1_en_q[g]),
            .a     (s1_a_q[g*LANE_W +: LANE_W]),
            .b     (s1_b_q[g*LANE_W +: LANE_W]),
            .res   (lane_res_c[g*LANE_W +: LANE_W]),
            .flags (lane_flags_c[g]),
            .div0  (div0_c[g])
        );
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            neg_c[i]   = lane_flags_c[i].neg;
            zero_c[i]  = lane_flags_c[i].zero;
            carry_c[i] = lane_flags_c[i].carry;
            ovf_c[i]   = lane_flags_c[i].ovf;
        end
    end

    assign adv2_c       = !out_valid_q || bus.out_ready;
    assign adv1_c       = !s1_valid_q || adv2_c;
    assign bus.in_ready = !rst && adv1_c;

    // Next-state: each stage loads only when the stage downstream can take its contents
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_en_d     = s1_en_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        neg_d       = neg_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        nop_d       = nop_q;
        err_d       = err_q;

        if (adv1_c) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d = bus.op;
                s1_en_d = bus.lane_en;
                s1_a_d  = bus.a;
                s1_b_d  = bus.b;
            end
        end

        if (adv2_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = lane_res_c;
                neg_d    = neg_c;
                zero_d   = zero_c;
                carry_d  = carry_c;
                ovf_d    = ovf_c;
                nop_d    = (s1_op_q == OP_NOP);
                err_d    = !is_legal_op(s1_op_q, LANE_W) || (|div0_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_en_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            neg_q       <= '0;
            zero_q      <= '0;
            carry_q     <= '0;
            ovf_q       <= '0;
            nop_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_en_q     <= s1_en_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            neg_q       <= neg_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            nop_q       <= nop_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.neg_flag   = neg_q;
    assign bus.zero_flag  = zero_q;
    assign bus.carry_flag = carry_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.nop_flag   = nop_q;
    assign bus.err_flag   = err_q;
endmodule
